// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: a constant clog2,
// the registered flag bundle, its reset value and a count-to-flags helper.
package fifo_pkg;

  // Ceiling log2 usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

  // Status flags that are always registered together.
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  // Flag values for an empty queue (reset and flush).
  localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

  // Derive every flag from an occupancy value.
  function automatic fifo_flags_t flags_of(input int cnt, input int depth,
                                           input int afull_th, input int aempty_th);
    fifo_flags_t f;
    f.full   = (cnt == depth);
    f.empty  = (cnt == 0);
    f.afull  = (cnt >= afull_th);
    f.aempty = (cnt <= aempty_th);
    return f;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking keeps stale data hidden.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [clog2(DEPTH)-1:0]    waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [clog2(DEPTH)-1:0]    raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Store the write word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock circular FIFO with optional first-word-fall-through,
// registered occupancy/threshold flags, synchronous flush and reject pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    w_en,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    r_en,
  output logic [WIDTH-1:0]        data_out,
  output logic                    mem_full,
  output logic                    mem_empty,
  output logic                    mem_afull,
  output logic                    mem_aempty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;   // extra MSB is the wrap bit
  localparam int CNT_W  = ADDR_W + 1;

  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;
  fifo_flags_t      flags_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             wr_acc_s;
  logic             rd_acc_s;
  logic [CNT_W-1:0] count_next_s;
  fifo_flags_t      flags_next_s;
  logic [WIDTH-1:0] rd_data_s;

  // Accept/reject decisions use only the current registered flags; flush blocks both.
  always_comb begin
    wr_acc_s = w_en && !flags_r.full && !flush;
    rd_acc_s = r_en && !flags_r.empty && !flush;
    if (flush) begin
      count_next_s = '0;
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_next_s = count_r + CNT_W'(1'b1);
        2'b01:   count_next_s = count_r - CNT_W'(1'b1);
        default: count_next_s = count_r;
      endcase
    end
    flags_next_s = flags_of(int'(count_next_s), DEPTH, AFULL_TH, AEMPTY_TH);
  end

  // Pointers, occupancy, flags and reject pulses; flush returns to the empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      count_r     <= '0;
      flags_r     <= FLAGS_RESET;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      count_r     <= '0;
      flags_r     <= FLAGS_RESET;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + PTR_W'(1'b1);
      end
      if (rd_acc_s) begin
        rptr_r <= rptr_r + PTR_W'(1'b1);
      end
      count_r     <= count_next_s;
      flags_r     <= flags_next_s;
      overflow_r  <= w_en && flags_r.full;
      underflow_r <= r_en && flags_r.empty;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wptr_r[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rptr_r[ADDR_W-1:0]),
    .rdata (rd_data_s)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while the queue is empty.
      always_comb begin
        if (flags_r.empty) begin
          data_out = '0;
        end else begin
          data_out = rd_data_s;
        end
      end
    end else begin : g_std
      logic [WIDTH-1:0] dout_r;
      // Registered read port: capture the head word on an accepted read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_r <= '0;
        end else if (flush) begin
          dout_r <= '0;
        end else if (rd_acc_s) begin
          dout_r <= rd_data_s;
        end
      end
      assign data_out = dout_r;
    end
  endgenerate

  assign mem_full   = flags_r.full;
  assign mem_empty  = flags_r.empty;
  assign mem_afull  = flags_r.afull;
  assign mem_aempty = flags_r.aempty;
  assign count      = count_r;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;

endmodule
